// File: rtl/rv32i_types.sv
// Shared RV32I core type definitions; arbiter FSM state and grant owner
// live here alongside the pipeline control types.
package rv32i_types;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_SERVE_I = 2'd1,
    ARB_SERVE_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } arb_grant_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
// Reusable for any performance event counter.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/cache_arbiter.sv
// Shares the single memory port between the I-cache and D-cache miss paths,
// round-robin on ties, with a saturating contention counter.
module cache_arbiter
  import rv32i_types::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_read,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_read,
  output logic              m_write,
  output logic [LINE_W-1:0] m_wdata,
  input  logic [LINE_W-1:0] m_rdata,
  input  logic              m_resp,
  input  logic              perf_clr,
  output logic [CNT_W-1:0]  contention_cnt
);

  arb_state_t state, next_state;
  arb_grant_t last_grant, grant_sel;
  logic       grant_valid;
  logic       op_write;
  logic       i_req, d_req;
  logic       contend;

  assign i_req = i_read;
  assign d_req = d_read | d_write;

  // Consumers qualify rdata with their own resp, so both sides see m_rdata.
  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;

  always_comb begin
    next_state  = state;
    grant_valid = 1'b0;
    grant_sel   = last_grant;
    m_read      = 1'b0;
    m_write     = 1'b0;
    i_resp      = 1'b0;
    d_resp      = 1'b0;
    contend     = 1'b0;
    case (state)
      ARB_IDLE: begin
        contend = i_req && d_req;
        if (i_req && d_req) begin
          grant_valid = 1'b1;
          grant_sel   = (last_grant == GRANT_D) ? GRANT_I : GRANT_D;
        end else if (i_req) begin
          grant_valid = 1'b1;
          grant_sel   = GRANT_I;
        end else if (d_req) begin
          grant_valid = 1'b1;
          grant_sel   = GRANT_D;
        end
        if (grant_valid) begin
          next_state = (grant_sel == GRANT_I) ? ARB_SERVE_I : ARB_SERVE_D;
        end
      end
      ARB_SERVE_I: begin
        contend = d_req;
        m_read  = 1'b1;
        i_resp  = m_resp;
        if (m_resp) begin
          next_state = ARB_IDLE;
        end
      end
      ARB_SERVE_D: begin
        contend = i_req;
        m_read  = ~op_write;
        m_write = op_write;
        d_resp  = m_resp;
        if (m_resp) begin
          next_state = ARB_IDLE;
        end
      end
      default: begin
        next_state = ARB_IDLE;
      end
    endcase
  end

  // Address, write data and op are captured only at the grant edge so the
  // memory side never sees requester inputs change mid-transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB_IDLE;
      last_grant <= GRANT_D;
      op_write   <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
    end else begin
      state <= next_state;
      if (grant_valid) begin
        last_grant <= grant_sel;
        if (grant_sel == GRANT_I) begin
          m_addr   <= i_addr;
          op_write <= 1'b0;
        end else begin
          m_addr   <= d_addr;
          m_wdata  <= d_wdata;
          op_write <= d_write;
        end
      end
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_contention (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (contend),
    .clr  (perf_clr),
    .count(contention_cnt)
  );

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed-vector bench for cache_arbiter; a narrow contention counter
// makes saturation reachable in a short run.
module tb_cache_arbiter;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              rst_n;
  logic [ADDR_W-1:0] i_addr;
  logic              i_read;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic [ADDR_W-1:0] d_addr;
  logic              d_read;
  logic              d_write;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic [ADDR_W-1:0] m_addr;
  logic              m_read;
  logic              m_write;
  logic [LINE_W-1:0] m_wdata;
  logic [LINE_W-1:0] m_rdata;
  logic              m_resp;
  logic              perf_clr;
  logic [CNT_W-1:0]  contention_cnt;

  int vectors;
  int miscompares;

  localparam logic [LINE_W-1:0] LINE_A5   = {32{8'hA5}};
  localparam logic [LINE_W-1:0] LINE_BEEF = {8{32'hDEADBEEF}};

  cache_arbiter #(
    .ADDR_W(ADDR_W),
    .LINE_W(LINE_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_addr        (i_addr),
    .i_read        (i_read),
    .i_rdata       (i_rdata),
    .i_resp        (i_resp),
    .d_addr        (d_addr),
    .d_read        (d_read),
    .d_write       (d_write),
    .d_wdata       (d_wdata),
    .d_rdata       (d_rdata),
    .d_resp        (d_resp),
    .m_addr        (m_addr),
    .m_read        (m_read),
    .m_write       (m_write),
    .m_wdata       (m_wdata),
    .m_rdata       (m_rdata),
    .m_resp        (m_resp),
    .perf_clr      (perf_clr),
    .contention_cnt(contention_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_addr   = '0;
    i_read   = 1'b0;
    d_addr   = '0;
    d_read   = 1'b0;
    d_write  = 1'b0;
    d_wdata  = '0;
    m_rdata  = '0;
    m_resp   = 1'b0;
    perf_clr = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
  endtask

  // Async reset while a writeback is on the bus must drop m_write at once.
  task automatic test_reset();
    do_reset();
    vectors++;
    if (m_read !== 1'b0 || m_write !== 1'b0 || i_resp !== 1'b0 || d_resp !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_ctrl: got rd=%b wr=%b ir=%b dr=%b want all 0", m_read, m_write, i_resp, d_resp);
    end
    vectors++;
    if (m_addr !== '0 || m_wdata !== '0 || contention_cnt !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_data: got addr=%h cnt=%0d want 0/0", m_addr, contention_cnt);
    end
    d_write = 1'b1;
    d_addr  = 32'h0000_2000;
    d_wdata = LINE_BEEF;
    tick();
    vectors++;
    if (m_write !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_pre_write: got %b want 1", m_write);
    end
    #3 rst_n = 1'b0;
    #1;
    vectors++;
    if (m_write !== 1'b0 || m_read !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_async_drop: got wr=%b rd=%b want 0/0", m_write, m_read);
    end
    d_write = 1'b0;
    d_wdata = '0;
    d_addr  = '0;
    #2 rst_n = 1'b1;
    tick();
    vectors++;
    if (m_write !== 1'b0 || m_read !== 1'b0 || m_addr !== '0 || m_wdata !== '0 || contention_cnt !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_release: got wr=%b rd=%b addr=%h cnt=%0d want all 0", m_write, m_read, m_addr, contention_cnt);
    end
  endtask

  task automatic test_i_only();
    do_reset();
    i_read = 1'b1;
    i_addr = 32'h60;
    tick();
    vectors++;
    if (m_read !== 1'b1 || m_write !== 1'b0 || m_addr !== 32'h60) begin
      miscompares++;
      $display("[TB] FAIL i_only_issue: got rd=%b wr=%b addr=%h want 1/0/60", m_read, m_write, m_addr);
    end
    tick();
    tick();
    tick();
    m_resp  = 1'b1;
    m_rdata = LINE_A5;
    #1;
    vectors++;
    if (i_resp !== 1'b1 || i_rdata !== LINE_A5 || d_resp !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL i_only_resp: got ir=%b dr=%b rdata=%h", i_resp, d_resp, i_rdata);
    end
    tick();
    m_resp  = 1'b0;
    i_read  = 1'b0;
    m_rdata = '0;
    #1;
    vectors++;
    if (m_read !== 1'b0 || i_resp !== 1'b0 || d_resp !== 1'b0 || contention_cnt !== 4'd0) begin
      miscompares++;
      $display("[TB] FAIL i_only_done: got rd=%b ir=%b dr=%b cnt=%0d want 0/0/0/0", m_read, i_resp, d_resp, contention_cnt);
    end
  endtask

  task automatic test_tie();
    do_reset();
    i_read = 1'b1;
    i_addr = 32'h100;
    d_read = 1'b1;
    d_addr = 32'h200;
    tick();
    vectors++;
    if (m_read !== 1'b1 || m_addr !== 32'h100) begin
      miscompares++;
      $display("[TB] FAIL tie_first_i: got rd=%b addr=%h want 1/100", m_read, m_addr);
    end
    tick();
    tick();
    tick();
    m_resp = 1'b1;
    #1;
    vectors++;
    if (i_resp !== 1'b1 || d_resp !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL tie_i_resp: got ir=%b dr=%b want 1/0", i_resp, d_resp);
    end
    tick();
    m_resp = 1'b0;
    i_read = 1'b0;
    #1;
    vectors++;
    if (m_read !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL tie_idle_gap: got rd=%b want 0", m_read);
    end
    tick();
    vectors++;
    if (m_read !== 1'b1 || m_addr !== 32'h200 || contention_cnt !== 4'd5) begin
      miscompares++;
      $display("[TB] FAIL tie_d_issue: got rd=%b addr=%h cnt=%0d want 1/200/5", m_read, m_addr, contention_cnt);
    end
    tick();
    m_resp = 1'b1;
    #1;
    vectors++;
    if (d_resp !== 1'b1 || i_resp !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL tie_d_resp: got dr=%b ir=%b want 1/0", d_resp, i_resp);
    end
    tick();
    m_resp = 1'b0;
    d_read = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [ADDR_W-1:0] exp_addr [4];
    logic              exp_is_i [4];
    exp_addr[0] = 32'h300; exp_is_i[0] = 1'b1;
    exp_addr[1] = 32'h400; exp_is_i[1] = 1'b0;
    exp_addr[2] = 32'h300; exp_is_i[2] = 1'b1;
    exp_addr[3] = 32'h400; exp_is_i[3] = 1'b0;
    do_reset();
    i_read = 1'b1;
    i_addr = 32'h300;
    d_read = 1'b1;
    d_addr = 32'h400;
    for (int k = 0; k < 4; k++) begin
      tick();
      vectors++;
      if (m_addr !== exp_addr[k] || m_read !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL rr_grant%0d: got addr=%h rd=%b want %h/1", k, m_addr, m_read, exp_addr[k]);
      end
      tick();
      m_resp = 1'b1;
      #1;
      vectors++;
      if (i_resp !== exp_is_i[k] || d_resp !== !exp_is_i[k]) begin
        miscompares++;
        $display("[TB] FAIL rr_resp%0d: got ir=%b dr=%b want ir=%b", k, i_resp, d_resp, exp_is_i[k]);
      end
      tick();
      m_resp = 1'b0;
    end
    i_read = 1'b0;
    d_read = 1'b0;
    #1;
    vectors++;
    if (contention_cnt !== 4'd12) begin
      miscompares++;
      $display("[TB] FAIL rr_contention: got %0d want 12", contention_cnt);
    end
  endtask

  task automatic test_d_writeback();
    do_reset();
    d_write = 1'b1;
    d_addr  = 32'h1000;
    d_wdata = LINE_BEEF;
    tick();
    vectors++;
    if (m_write !== 1'b1 || m_read !== 1'b0 || m_addr !== 32'h1000 || m_wdata !== LINE_BEEF) begin
      miscompares++;
      $display("[TB] FAIL wb_issue: got wr=%b rd=%b addr=%h wdata=%h", m_write, m_read, m_addr, m_wdata);
    end
    tick();
    d_wdata = '0;
    d_addr  = 32'h0;
    #1;
    vectors++;
    if (m_wdata !== LINE_BEEF || m_addr !== 32'h1000 || m_write !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL wb_hold: got wr=%b addr=%h wdata=%h", m_write, m_addr, m_wdata);
    end
    tick();
    m_resp = 1'b1;
    #1;
    vectors++;
    if (d_resp !== 1'b1 || i_resp !== 1'b0 || m_wdata !== LINE_BEEF) begin
      miscompares++;
      $display("[TB] FAIL wb_resp: got dr=%b ir=%b wdata=%h", d_resp, i_resp, m_wdata);
    end
    tick();
    m_resp  = 1'b0;
    d_write = 1'b0;
    #1;
    vectors++;
    if (d_resp !== 1'b0 || m_write !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL wb_done: got dr=%b wr=%b want 0/0", d_resp, m_write);
    end
  endtask

  task automatic test_spurious_and_perf();
    do_reset();
    m_resp  = 1'b1;
    m_rdata = LINE_A5;
    #1;
    vectors++;
    if (i_resp !== 1'b0 || d_resp !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL spurious_resp: got ir=%b dr=%b want 0/0", i_resp, d_resp);
    end
    tick();
    m_resp  = 1'b0;
    m_rdata = '0;
    #1;
    vectors++;
    if (m_read !== 1'b0 || m_write !== 1'b0 || i_resp !== 1'b0 || d_resp !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL spurious_after: got rd=%b wr=%b ir=%b dr=%b want 0", m_read, m_write, i_resp, d_resp);
    end
    i_read = 1'b1;
    i_addr = 32'h40;
    d_read = 1'b1;
    d_addr = 32'h80;
    repeat (20) tick();
    vectors++;
    if (contention_cnt !== 4'hF) begin
      miscompares++;
      $display("[TB] FAIL perf_saturate: got %0d want 15", contention_cnt);
    end
    perf_clr = 1'b1;
    tick();
    vectors++;
    if (contention_cnt !== 4'd0) begin
      miscompares++;
      $display("[TB] FAIL perf_clear: got %0d want 0", contention_cnt);
    end
    perf_clr = 1'b0;
    tick();
    vectors++;
    if (contention_cnt !== 4'd1) begin
      miscompares++;
      $display("[TB] FAIL perf_resume: got %0d want 1", contention_cnt);
    end
    do_reset();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    test_reset();
    test_i_only();
    test_tie();
    test_round_robin();
    test_d_writeback();
    test_spurious_and_perf();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
